// File: rtl/keypad_pkg.sv
// keypad_pkg: shared types and constants for the keypad scanner.
//   state_t     - scanner FSM state encoding
//   NUM_RC      - keypad rows and columns per side (4x4 matrix)
//   HEX_LEGEND  - printed legend, indexed by {row[1:0], col[1:0]}
//   first_low() - index of the lowest active-low row bit
package keypad_pkg;

    localparam int NUM_RC = 4;

    typedef enum logic [1:0] {
        SCAN       = 2'd0,
        DB_PRESS   = 2'd1,
        HELD       = 2'd2,
        DB_RELEASE = 2'd3
    } state_t;

    // Entry [r*4+c]. Rows read 1 2 3 A / 4 5 6 B / 7 8 9 C / E 0 F D.
    // The concatenation is written from index 15 down to index 0.
    localparam logic [15:0][3:0] HEX_LEGEND = {
        4'hD, 4'hF, 4'h0, 4'hE,
        4'hC, 4'h9, 4'h8, 4'h7,
        4'hB, 4'h6, 4'h5, 4'h4,
        4'hA, 4'h3, 4'h2, 4'h1
    };

    // Row 0 wins when several rows are low together.
    function automatic logic [1:0] first_low(input logic [NUM_RC-1:0] r);
        if (!r[0])      return 2'd0;
        else if (!r[1]) return 2'd1;
        else if (!r[2]) return 2'd2;
        else            return 2'd3;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// sync_2ff: two-flop synchronizer for a bus of independent static levels.
//   clk   - destination clock
//   reset - synchronous, active-low; both stages load RESET_VAL
//   d     - asynchronous input bus
//   q     - synchronized output bus
module sync_2ff #(
    parameter int              W         = 4,
    parameter logic [W-1:0]    RESET_VAL = '1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] meta;

    always_ff @(posedge clk) begin
        if (!reset) begin
            meta <= RESET_VAL;
            q    <= RESET_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/keypad_scan_ctrl.sv
// keypad_scan_ctrl: 4x4 matrix keypad scanner with press/release debounce
// and single-key lockout.
//   clk       - system clock
//   reset     - synchronous, active-low
//   rows      - keypad rows, active-low, asynchronous to clk
//   cols      - column drive, active-low, exactly one column low
//   key_code  - code of the last accepted key, held between accepts
//   key_valid - one-cycle pulse on the first HELD cycle of an accepted key
//   key_held  - high while the key is held or its release is being debounced
// Build option: define KEYPAD_HEXMAP_EN to report the printed keypad legend
// in key_code; otherwise key_code is the raw {row, col} position.
module keypad_scan_ctrl
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV        = 1000,
    parameter int DEBOUNCE_CYCLES = 250000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NUM_RC-1:0] rows,
    output logic [NUM_RC-1:0] cols,
    output logic [3:0]        key_code,
    output logic              key_valid,
    output logic              key_held
);

    localparam int DW  = $clog2(SCAN_DIV);
    localparam int DBW = $clog2(DEBOUNCE_CYCLES);
    localparam logic [DW-1:0]  DWELL_LAST = DW'(SCAN_DIV - 1);
    localparam logic [DBW-1:0] DB_LAST    = DBW'(DEBOUNCE_CYCLES - 1);
    // First dwell cycles of a column still see the previous column's rows
    // through the synchronizer, so presses are only sampled from here on.
    localparam logic [DW-1:0]  DWELL_SETTLE = DW'(3);

    logic [NUM_RC-1:0] rs;

    sync_2ff #(.W(NUM_RC), .RESET_VAL('1)) u_sync (
        .clk   (clk),
        .reset (reset),
        .d     (rows),
        .q     (rs)
    );

    state_t            state,     state_n;
    logic [1:0]        col_idx,   col_idx_n;
    logic [1:0]        row_idx,   row_idx_n;
    logic [NUM_RC-1:0] snap,      snap_n;
    logic [DW-1:0]     dwell_cnt, dwell_cnt_n;
    logic [DBW-1:0]    db_cnt,    db_cnt_n;
    logic [3:0]        key_code_n;
    logic              key_valid_n;
    logic [3:0]        code_sel;

`ifdef KEYPAD_HEXMAP_EN
    assign code_sel = HEX_LEGEND[{row_idx, col_idx}];
`else
    assign code_sel = {row_idx, col_idx};
`endif

    assign cols     = ~(4'b0001 << col_idx);
    assign key_held = (state == HELD) || (state == DB_RELEASE);

    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= SCAN;
            col_idx   <= '0;
            row_idx   <= '0;
            snap      <= '1;
            dwell_cnt <= '0;
            db_cnt    <= '0;
            key_code  <= '0;
            key_valid <= 1'b0;
        end else begin
            state     <= state_n;
            col_idx   <= col_idx_n;
            row_idx   <= row_idx_n;
            snap      <= snap_n;
            dwell_cnt <= dwell_cnt_n;
            db_cnt    <= db_cnt_n;
            key_code  <= key_code_n;
            key_valid <= key_valid_n;
        end
    end

    always_comb begin
        state_n     = state;
        col_idx_n   = col_idx;
        row_idx_n   = row_idx;
        snap_n      = snap;
        dwell_cnt_n = dwell_cnt;
        db_cnt_n    = db_cnt;
        key_code_n  = key_code;
        key_valid_n = 1'b0;

        case (state)
            SCAN: begin
                if (dwell_cnt >= DWELL_SETTLE && rs != '1) begin
                    // Column stays frozen while the press is debounced.
                    state_n   = DB_PRESS;
                    row_idx_n = first_low(rs);
                    snap_n    = rs;
                    db_cnt_n  = '0;
                end else if (dwell_cnt == DWELL_LAST) begin
                    dwell_cnt_n = '0;
                    col_idx_n   = col_idx + 2'd1;
                end else begin
                    dwell_cnt_n = dwell_cnt + DW'(1);
                end
            end

            DB_PRESS: begin
                if (rs != snap) begin
                    state_n     = SCAN;
                    dwell_cnt_n = '0;
                    col_idx_n   = col_idx + 2'd1;
                end else if (db_cnt == DB_LAST) begin
                    state_n     = HELD;
                    key_code_n  = code_sel;
                    key_valid_n = 1'b1;
                end else begin
                    db_cnt_n = db_cnt + DBW'(1);
                end
            end

            HELD: begin
                // Any row activity other than a full release is ignored.
                if (rs == '1) begin
                    state_n  = DB_RELEASE;
                    db_cnt_n = '0;
                end
            end

            DB_RELEASE: begin
                if (rs != '1) begin
                    state_n = HELD;
                end else if (db_cnt == DB_LAST) begin
                    state_n     = SCAN;
                    dwell_cnt_n = '0;
                    col_idx_n   = col_idx + 2'd1;
                end else begin
                    db_cnt_n = db_cnt + DBW'(1);
                end
            end

            default: state_n = SCAN;
        endcase
    end

endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// tb_keypad_scan_ctrl: directed bench for keypad_scan_ctrl using a 4x4
// keypad matrix model (a pressed key pulls its row low only while its
// column is driven) and a scoreboard of expected key codes.
// Build option: KEYPAD_HEXMAP_EN selects legend-coded expectations.
module tb_keypad_scan_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  rows;
    logic [3:0]  cols;
    logic [3:0]  key_code;
    logic        key_valid;
    logic        key_held;
    logic [15:0] keys;      // keys[r*4+c] = 1 while key (r,c) is pressed

    int errors = 0;
    int checks = 0;
    int vld_cnt = 0;
    logic [3:0] exp_q[$];
    logic [3:0] obs_q[$];

`ifdef KEYPAD_HEXMAP_EN
    localparam logic [3:0] K_R1C2 = 4'h6;
    localparam logic [3:0] K_R0C0 = 4'h1;
    localparam logic [3:0] K_R2C1 = 4'h8;
    localparam logic [3:0] K_R1C3 = 4'hB;
`else
    localparam logic [3:0] K_R1C2 = 4'h6;
    localparam logic [3:0] K_R0C0 = 4'h0;
    localparam logic [3:0] K_R2C1 = 4'h9;
    localparam logic [3:0] K_R1C3 = 4'h7;
`endif

    keypad_scan_ctrl #(.SCAN_DIV(8), .DEBOUNCE_CYCLES(16)) dut (
        .clk       (clk),
        .reset     (reset),
        .rows      (rows),
        .cols      (cols),
        .key_code  (key_code),
        .key_valid (key_valid),
        .key_held  (key_held)
    );

    always #5 clk = ~clk;

    always_comb begin
        rows = 4'hF;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (keys[r*4+c] && !cols[c]) rows[r] = 1'b0;
    end

    // Pulse monitor: records every accepted key code.
    always @(negedge clk) begin
        if (reset === 1'b1 && key_valid === 1'b1) begin
            vld_cnt <= vld_cnt + 1;
            obs_q.push_back(key_code);
        end
    end

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] want);
        checks++;
        assert (got === want) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, got, want);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Waits for the cycle in which column c has just started being driven.
    task automatic wait_col(input int c, input string tag);
        logic [3:0] tgt, prev;
        int n;
        tgt  = ~(4'b0001 << c);
        prev = cols;
        n    = 0;
        @(negedge clk);
        while (!(cols == tgt && prev != tgt) && n < 200) begin
            prev = cols;
            @(negedge clk);
            n++;
        end
        chk({tag, "_col_wait"}, 8'(n < 200), 8'd1);
    endtask

    task automatic wait_held(input logic val, input string tag);
        int n;
        n = 0;
        while (key_held !== val && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_held_wait"}, 8'(n < 200), 8'd1);
    endtask

    task automatic wait_pulse(input int base, input string tag);
        int n;
        n = 0;
        while (vld_cnt == base && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_pulse_wait"}, 8'(n < 200), 8'd1);
    endtask

    // Scoreboard drain: pulse count, then each observed code against the queue.
    task automatic score(input string tag, input int base, input int n_exp);
        logic [3:0] o, e;
        chk({tag, "_pulses"}, 8'(vld_cnt - base), 8'(n_exp));
        while (obs_q.size() > 0) begin
            o = obs_q.pop_front();
            e = (exp_q.size() > 0) ? exp_q.pop_front() : 4'hx;
            chk({tag, "_code"}, {4'h0, o}, {4'h0, e});
        end
        exp_q.delete();
    endtask

    initial begin
        int base;
        keys  = '0;
        reset = 1'b0;
        cyc(3);
        chk("rst_cols",  {4'h0, cols},     8'h0E);
        chk("rst_valid", {7'h0, key_valid}, 8'h00);
        chk("rst_held",  {7'h0, key_held},  8'h00);
        chk("rst_code",  {4'h0, key_code},  8'h00);
        reset = 1'b1;

        // Single press of row 1 / col 2 for 40 cycles.
        base = vld_cnt;
        wait_col(2, "single");
        keys[1*4+2] = 1'b1;
        exp_q.push_back(K_R1C2);
        cyc(40);
        chk("single_held", {7'h0, key_held}, 8'h01);
        chk("single_code", {4'h0, key_code}, {4'h0, K_R1C2});
        keys = '0;
        wait_held(1'b0, "single_rel");
        score("single", base, 1);

        // Bounce on row 0 / col 0: low 5, high 2, then low until accepted.
        base = vld_cnt;
        wait_col(0, "bounce");
        keys[0] = 1'b1;
        cyc(5);
        keys[0] = 1'b0;
        cyc(2);
        keys[0] = 1'b1;
        exp_q.push_back(K_R0C0);
        cyc(3);
        chk("bounce_first_abort", {4'h0, cols}, 8'h0D);
        wait_pulse(base, "bounce");
        cyc(5);
        keys = '0;
        wait_held(1'b0, "bounce_rel");
        score("bounce", base, 1);

        // Second key on the same column while the first is held.
        base = vld_cnt;
        wait_col(2, "lock");
        keys[1*4+2] = 1'b1;
        exp_q.push_back(K_R1C2);
        cyc(30);
        keys[3*4+2] = 1'b1;
        cyc(20);
        chk("lock_held_both", {7'h0, key_held}, 8'h01);
        keys[1*4+2] = 1'b0;
        cyc(10);
        chk("lock_held_second", {7'h0, key_held}, 8'h01);
        keys = '0;
        wait_held(1'b0, "lock_rel");
        score("lock", base, 1);

        // Release glitch on row 2 / col 1.
        base = vld_cnt;
        wait_col(1, "glitch");
        keys[2*4+1] = 1'b1;
        exp_q.push_back(K_R2C1);
        cyc(30);
        keys = '0;
        cyc(10);
        chk("glitch_dbrel_held", {7'h0, key_held}, 8'h01);
        keys[2*4+1] = 1'b1;
        cyc(1);
        keys = '0;
        cyc(4);
        chk("glitch_back_held", {7'h0, key_held}, 8'h01);
        wait_held(1'b0, "glitch_rel");
        chk("glitch_next_col", {4'h0, cols}, 8'h0B);
        score("glitch", base, 1);

        // Rows 1 and 3 low together on col 3: row 1 wins.
        base = vld_cnt;
        wait_col(3, "multi");
        keys[1*4+3] = 1'b1;
        keys[3*4+3] = 1'b1;
        exp_q.push_back(K_R1C3);
        cyc(30);
        chk("multi_code", {4'h0, key_code}, {4'h0, K_R1C3});
        keys = '0;
        wait_held(1'b0, "multi_rel");
        score("multi", base, 1);

        // Reset during press debounce (db_cnt=10) on row 0 / col 2.
        base = vld_cnt;
        wait_col(2, "rstdb");
        keys[2] = 1'b1;
        cyc(14);
        chk("rstdb_pre_cols", {4'h0, cols}, 8'h0B);
        reset = 1'b0;
        keys  = '0;
        cyc(1);
        chk("rstdb_cols",  {4'h0, cols},      8'h0E);
        chk("rstdb_valid", {7'h0, key_valid}, 8'h00);
        chk("rstdb_code",  {4'h0, key_code},  8'h00);
        cyc(1);
        reset = 1'b1;
        cyc(40);
        score("rstdb", base, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/keypad_scan_ctrl.md
KEYPAD_SCAN_CTRL -- requirements
Module: keypad_scan_ctrl

Interface
REQ-001 SHALL have parameter SCAN_DIV, default 1000: clk cycles each column is driven while scanning; legal range is 4 or more.
REQ-002 SHALL have parameter DEBOUNCE_CYCLES, default 250000: clk cycles a row pattern must be stable to be accepted; legal range is 2 or more.
REQ-003 SHALL have port clk, input, 1 bit: system clock.
REQ-004 SHALL have port reset, input, 1 bit: synchronous, active-low reset.
REQ-005 SHALL have port rows, input, 4 bits: keypad rows, active-low, asynchronous to clk.
REQ-006 SHALL have port cols, output, 4 bits: keypad column drive, active-low, one-hot-low.
REQ-007 SHALL have port key_code, output, 4 bits: code of the last accepted key.
REQ-008 SHALL have port key_valid, output, 1 bit: one-cycle pulse when a key is accepted.
REQ-009 SHALL have port key_held, output, 1 bit: high while the accepted key is held or its release is being debounced.

Function
REQ-010 SHALL pass rows through a 2-flop synchronizer; all logic uses only the synchronized value rs.
REQ-011 SHALL implement states SCAN, DB_PRESS, HELD and DB_RELEASE.
REQ-012 SCAN: SHALL drive col_idx low and run dwell_cnt from 0 to SCAN_DIV-1; on wrap, col_idx advances by 1 modulo 4 (3 to 0).
REQ-013 SCAN: SHALL check for a press only when dwell_cnt >= 3; press = any rs bit low; otherwise ignore rs.
REQ-014 On press: SHALL freeze col_idx and latch row_idx = lowest-index low bit of rs (row 0 has highest priority) and snapshot rs; next state DB_PRESS with db_cnt=0.
REQ-015 DB_PRESS: while rs equals the snapshot, db_cnt increments each cycle.
REQ-016 DB_PRESS: if rs differs from the snapshot, SHALL return to SCAN, reset dwell_cnt and advance col_idx.
REQ-017 DB_PRESS: with db_cnt==DEBOUNCE_CYCLES-1 and rs stable, next cycle SHALL be HELD, with key_code updated and key_valid=1 in that cycle only.
REQ-018 HELD: SHALL ignore all other keys (single-key lockout); on rs==4'hF, SHALL go to DB_RELEASE with db_cnt=0.
REQ-019 DB_RELEASE: any rs bit low SHALL return to HELD with no new key_valid; DEBOUNCE_CYCLES consecutive rs==4'hF cycles SHALL go to SCAN with col_idx+1 and dwell_cnt=0.
REQ-020 SHALL hold key_code between accepts; key_held=1 in HELD and DB_RELEASE, else 0.
REQ-021 SHALL size counters with $clog2 of their parameter; counters never wrap past their terminal value.

Reset
REQ-022 With reset==0 at a clk edge: state=SCAN, col_idx=0, cols=4'b1110, dwell_cnt=0, db_cnt=0, key_code=0, key_valid=0, key_held=0, synchronizer flops=4'hF.
REQ-023 Reset in any state SHALL abort the debounce with no key_valid pulse.

Configuration
REQ-024 Macro KEYPAD_HEXMAP_EN defined: key_code SHALL be the keypad legend. By row 0-3, columns 0-3: 1 2 3 A / 4 5 6 B / 7 8 9 C / E 0 F D.
REQ-025 Macro undefined: key_code SHALL be {row_idx[1:0], col_idx[1:0]}.

Structure
REQ-026 Package keypad_pkg SHALL hold the state enum, the 16-entry hex legend constant, and the row/column count constant 4.
REQ-027 The synchronizer SHALL be sub-module sync_2ff, 4 bits wide, with a reset value of all ones.

Verification (SCAN_DIV=8, DEBOUNCE_CYCLES=16)
REQ-028 Hold row 1 low while col 2 is driven, for 40 cycles -> exactly one key_valid; key_code=4'h6 with the macro, or 4'h6 ({01,10}) without.
REQ-029 Bounce: row 0 low 5 cycles, high 2, low 30, while col 0 is driven -> the first attempt aborts, the second is accepted; exactly one key_valid; key_code=4'h1 (macro) or 4'h0 (raw).
REQ-030 Accept a key, then press a second key while it is held -> no second key_valid; key_held stays 1.
REQ-031 Release glitch: all rows high 10 cycles, then row low 1 cycle -> returns to HELD with no key_valid; a full 16-cycle release -> SCAN, key_held=0.
REQ-032 Rows 1 and 3 low together on col 3 -> key_code=4'hB (macro) or 4'h7 (raw).
REQ-033 reset=0 in DB_PRESS at db_cnt=10 -> no key_valid; cols=4'b1110 on the next cycle.
